// File: rtl/fetch_unit.sv
// fetch_unit: instruction prefetcher with a circular queue of {pc, word} entries.
// It keeps at most one instruction-memory read outstanding, and it issues a read
// only when the queue has a slot reserved for the returning word.
// Ports:
//   clk, reset                     clock and synchronous active-high reset
//   redirect_valid, redirect_pc    flush the queue and restart fetch (bits [1:0] ignored)
//   mem_req, mem_addr              read request; address held until the ack cycle
//   mem_ack, mem_rdata             read completion and returned word
//   inst_valid, inst, inst_pc      queue head presented to the consumer
//   inst_ready                     consumer pops the head when inst_valid is set
module fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_DISCARD = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_next;
    logic [31:0]   req_addr;
    logic [31:0]   req_addr_next;
    logic [CW-1:0] count;
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [31:0]   q_pc   [DEPTH];
    logic [31:0]   q_word [DEPTH];

    logic          push;
    logic          pop;
    logic [CW:0]   count_after;
    logic [31:0]   redirect_word;

    assign redirect_word = redirect_pc & ~32'd3;
    // Occupancy after this cycle's push, used to decide whether another request fits.
    assign count_after   = (CW + 1)'(count) + (CW + 1)'(1) - (CW + 1)'(pop);

    assign mem_req    = (state != S_IDLE);
    assign mem_addr   = req_addr;
    assign inst_valid = (count != '0);
    assign inst       = q_word[head];
    assign inst_pc    = q_pc[head];

    // Next-state, request address and queue push/pop decisions.
    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        req_addr_next = req_addr;
        push          = 1'b0;
        // Redirect flushes the queue, so a same-cycle pop is not a real pop.
        pop           = inst_valid & inst_ready & ~redirect_valid;

        case (state)
            S_IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_word;
                end else if (count < CW'(DEPTH)) begin
                    state_next    = S_WAIT;
                    req_addr_next = fetch_pc;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_word;
                    // An ack in the redirect cycle retires the request; otherwise drain it.
                    state_next    = mem_ack ? S_IDLE : S_DISCARD;
                end else if (mem_ack) begin
                    push          = 1'b1;
                    fetch_pc_next = req_addr + 32'd4;
                    if (count_after < (CW + 1)'(DEPTH)) begin
                        req_addr_next = req_addr + 32'd4;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            S_DISCARD: begin
                if (redirect_valid) begin
                    fetch_pc_next = redirect_word;
                end
                if (mem_ack) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Control state, addresses and queue pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            fetch_pc <= RESET_PC;
            req_addr <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            req_addr <= req_addr_next;
            if (redirect_valid) begin
                count <= '0;
                head  <= tail;
            end else begin
                if (push) begin
                    tail <= tail + PW'(1);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Queue storage; contents are meaningful only below count.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            q_pc[tail]   <= req_addr;
            q_word[tail] <= mem_rdata;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus for fetch_unit with a scoreboard monitor.
// The stimulus loads the expected pc stream into a queue, and the monitor checks
// every accepted instruction against it. Memory words are a fixed function of
// the address.
module tb_fetch_unit;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int          lat;
    logic        mem_en;
    logic        force_ack;
    logic [3:0]  wait_cnt;
    int          ack_count = 0;
    int          ack_base;

    logic [31:0] exp_q[$];
    logic [31:0] e_pc;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hC3A5_5A3C;
    endfunction

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ack        (mem_ack),
        .mem_rdata      (mem_rdata),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    // Memory model: acks a request lat cycles after it is first presented.
    assign mem_ack   = (mem_en && mem_req && (int'(wait_cnt) == lat)) || force_ack;
    assign mem_rdata = word_of(mem_addr);

    always @(posedge clk) begin
        if (reset || !mem_req || mem_ack) wait_cnt <= '0;
        else                              wait_cnt <= wait_cnt + 4'd1;
        if (!reset && mem_req && mem_ack) ack_count <= ack_count + 1;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_from(input logic [31:0] pc, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(pc + 32'(4 * i));
    endtask

    // Holds reset for two edges, then releases it in the cycle before the first fetch edge.
    task automatic do_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        force_ack      = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every accepted head must match the next expected pc and word.
    always @(negedge clk) begin
        if (!reset && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_empty: got pc %h expected no instruction", inst_pc);
            end else begin
                e_pc = exp_q.pop_front();
                check32("sb_pc", inst_pc, e_pc);
                check32("sb_inst", inst, word_of(e_pc));
            end
        end
    end

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        inst_ready     = 1'b0;
        mem_en         = 1'b1;
        lat            = 0;
        force_ack      = 1'b0;
        step(2);
        check32("rst_mem_req", 32'(mem_req), 32'd0);
        check32("rst_inst_valid", 32'(inst_valid), 32'd0);
        check32("rst_mem_addr", mem_addr, RESET_PC);

        // Fill with the consumer stalled, then resume and stream at full rate.
        expect_from(RESET_PC, 64);
        ack_base = ack_count;
        reset = 1'b0;
        check32("first_cycle_idle", 32'(mem_req), 32'd0);
        step(1);
        check32("first_req", 32'(mem_req), 32'd1);
        check32("first_addr", mem_addr, RESET_PC);
        step(4);
        check32("full_req_off", 32'(mem_req), 32'd0);
        check32("full_valid", 32'(inst_valid), 32'd1);
        check32("full_head_pc", inst_pc, 32'h0);
        step(3);
        check32("full_ack_count", 32'(ack_count - ack_base), 32'd4);
        check32("full_still_idle", 32'(mem_req), 32'd0);
        inst_ready = 1'b1;
        step(1);
        check32("resume_wait_space", 32'(mem_req), 32'd0);
        step(1);
        check32("resume_req", 32'(mem_req), 32'd1);
        check32("resume_addr", mem_addr, 32'h10);
        for (int i = 0; i < 4; i++) begin
            step(1);
            check32("stream_valid", 32'(inst_valid), 32'd1);
            check32("stream_pc", inst_pc, 32'hC + 32'(4 * i));
        end

        // Redirect while a slow read is outstanding.
        lat = 3;
        exp_q.delete();
        do_reset();
        step(1);
        check32("slow_req", 32'(mem_req), 32'd1);
        step(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        expect_from(32'h100, 64);
        step(1);
        redirect_valid = 1'b0;
        check32("discard_req", 32'(mem_req), 32'd1);
        check32("discard_addr_hold", mem_addr, 32'h0);
        check32("discard_valid", 32'(inst_valid), 32'd0);
        step(1);
        check32("discard_ack", 32'(mem_ack), 32'd1);
        check32("discard_addr_ack", mem_addr, 32'h0);
        step(1);
        check32("discard_idle", 32'(mem_req), 32'd0);
        step(1);
        check32("redir_req", 32'(mem_req), 32'd1);
        check32("redir_addr", mem_addr, 32'h100);
        step(4);
        check32("redir_valid", 32'(inst_valid), 32'd1);
        check32("redir_head_pc", inst_pc, 32'h100);

        // Redirect colliding with an ack and a pop in the same cycle.
        lat = 0;
        do_reset();
        expect_from(RESET_PC, 64);
        step(3);
        check32("coll_pre_ack", 32'(mem_ack), 32'd1);
        check32("coll_pre_valid", 32'(inst_valid), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        expect_from(32'h40, 64);
        step(1);
        redirect_valid = 1'b0;
        check32("coll_flush_valid", 32'(inst_valid), 32'd0);
        check32("coll_idle", 32'(mem_req), 32'd0);
        step(1);
        check32("coll_addr", mem_addr, 32'h40);
        step(1);
        check32("coll_head_pc", inst_pc, 32'h40);

        // Unaligned redirect near the top of the address space wraps to zero.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        expect_from(32'hFFFF_FFFC, 64);
        step(1);
        redirect_valid = 1'b0;
        step(1);
        check32("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        step(1);
        check32("wrap_pc0", inst_pc, 32'hFFFF_FFFC);
        step(1);
        check32("wrap_pc1", inst_pc, 32'h0);
        step(1);
        check32("wrap_pc2", inst_pc, 32'h4);

        // Reset with queued entries and a live request; a late ack must be ignored.
        inst_ready = 1'b0;
        exp_q.delete();
        do_reset();
        step(3);
        check32("mid_req", 32'(mem_req), 32'd1);
        check32("mid_valid", 32'(inst_valid), 32'd1);
        reset  = 1'b1;
        mem_en = 1'b0;
        step(1);
        check32("mid_rst_valid", 32'(inst_valid), 32'd0);
        check32("mid_rst_req", 32'(mem_req), 32'd0);
        reset     = 1'b0;
        force_ack = 1'b1;
        step(1);
        force_ack = 1'b0;
        check32("late_ack_valid", 32'(inst_valid), 32'd0);
        check32("late_ack_req", 32'(mem_req), 32'd1);
        check32("late_ack_addr", mem_addr, RESET_PC);
        mem_en     = 1'b1;
        inst_ready = 1'b1;
        expect_from(RESET_PC, 64);
        step(1);
        check32("after_rst_pc", inst_pc, RESET_PC);
        step(2);
        inst_ready = 1'b0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
